// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: shared parity modes, FSM state encodings and stop-bit constants for the UART RX frame checker
package uart_rx_pkg;

  typedef enum logic [1:0] {
    PAR_EVEN  = 2'b00,
    PAR_ODD   = 2'b01,
    PAR_MARK  = 2'b10,
    PAR_SPACE = 2'b11
  } par_mode_e;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DATA   = 3'd1,
    PARITY = 3'd2,
    STOP1  = 3'd3,
    STOP2  = 3'd4
  } state_e;

  localparam logic STOP_ONE = 1'b0;
  localparam logic STOP_TWO = 1'b1;

  function automatic logic expected_parity(input par_mode_e mode, input logic acc);
    return mode == PAR_EVEN ? acc :
           mode == PAR_ODD  ? ~acc :
           mode == PAR_MARK ? 1'b1 : 1'b0;
  endfunction

endpackage

// File: rtl/uart_rx_parity_calc.sv
// uart_rx_parity_calc: serial XOR accumulator over the data bits plus the expected parity-bit mux
module uart_rx_parity_calc
  import uart_rx_pkg::*;
(
  input  logic      CLK,
  input  logic      RST,
  input  logic      clr,
  input  logic      bit_en,
  input  logic      bit_in,
  input  par_mode_e mode,
  output logic      expected
);

  logic acc;

  // Running XOR of the data bits, cleared at the start of each frame
  always_ff @(posedge CLK or negedge RST)
    if (!RST) acc <= 1'b0;
    else if (clr) acc <= 1'b0;
    else if (bit_en) acc <= acc ^ bit_in;

  // Value the parity bit must carry for the latched mode
  always_comb expected = expected_parity(mode, acc);

endmodule

// File: rtl/uart_rx_frame_check.sv
// uart_rx_frame_check: bit-serial UART frame assembler with parity and stop-bit checking.
// Optional macro UART_RX_ERR_COUNT_EN adds saturating parity/stop error counters and Cnt_Clr.
module uart_rx_frame_check
  import uart_rx_pkg::*;
#(
  parameter int Data_Width = 8,
  parameter int Len_Width  = 4
`ifdef UART_RX_ERR_COUNT_EN
  ,
  parameter int Cnt_Width  = 8
`endif
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  Frame_Start,
  input  logic                  Bit_Valid,
  input  logic                  Sampled_bit,
  input  logic [Len_Width-1:0]  Data_Len,
  input  logic                  Parity_EN,
  input  logic [1:0]            Parity_MODE,
  input  logic                  Stop_Bits,
  output logic [Data_Width-1:0] P_DATA,
  output logic                  Frame_Done,
  output logic                  Data_Valid,
  output logic                  Parity_ERR,
  output logic                  Stop_ERR,
  output logic                  Busy
`ifdef UART_RX_ERR_COUNT_EN
  ,
  input  logic                  Cnt_Clr,
  output logic [Cnt_Width-1:0]  Parity_ERR_CNT,
  output logic [Cnt_Width-1:0]  Stop_ERR_CNT
`endif
);

  localparam logic [Len_Width-1:0] MAX_LEN = Len_Width'(Data_Width);

  state_e               state, state_nx;
  logic [Len_Width-1:0] cnt, len_q, len_in;
  logic                 par_en_q, stop2_q, done_q;
  par_mode_e            mode_q;
  logic                 strobe, last_data, complete, exp_par;

  assign len_in    = (Data_Len == '0 || Data_Len > MAX_LEN) ? MAX_LEN : Data_Len;
  // A strobe coinciding with Frame_Start belongs to no frame and is dropped
  assign strobe    = Bit_Valid & ~Frame_Start;
  assign last_data = cnt == len_q - Len_Width'(1);
  assign complete  = strobe & ((state == STOP1 && stop2_q == STOP_ONE) || state == STOP2);

  uart_rx_parity_calc u_par (
    .CLK      (CLK),
    .RST      (RST),
    .clr      (Frame_Start),
    .bit_en   (strobe && state == DATA),
    .bit_in   (Sampled_bit),
    .mode     (mode_q),
    .expected (exp_par)
  );

  // State register
  always_ff @(posedge CLK or negedge RST)
    if (!RST) state <= IDLE;
    else state <= state_nx;

  // Next-state: Frame_Start restarts from any state, otherwise advance one field per strobe
  always_comb begin
    state_nx = state;
    if (Frame_Start) state_nx = DATA;
    else if (Bit_Valid)
      case (state)
        DATA:    if (last_data) state_nx = par_en_q ? PARITY : STOP1;
        PARITY:  state_nx = STOP1;
        STOP1:   state_nx = stop2_q == STOP_TWO ? STOP2 : IDLE;
        STOP2:   state_nx = IDLE;
        default: state_nx = state;
      endcase
  end

  // FSM outputs: done pulse is registered so results are already settled when it rises
  always_comb begin
    Busy       = state != IDLE;
    Frame_Done = done_q;
    Data_Valid = done_q & ~Parity_ERR & ~Stop_ERR;
  end

  // Frame configuration is sampled only at Frame_Start so mid-frame input changes are ignored
  always_ff @(posedge CLK or negedge RST)
    if (!RST) begin
      len_q    <= '0;
      par_en_q <= 1'b0;
      mode_q   <= PAR_EVEN;
      stop2_q  <= STOP_ONE;
    end else if (Frame_Start) begin
      len_q    <= len_in;
      par_en_q <= Parity_EN;
      mode_q   <= par_mode_e'(Parity_MODE);
      stop2_q  <= Stop_Bits;
    end

  // Data shifter, bit counter, error flags and completion pulse
  always_ff @(posedge CLK or negedge RST)
    if (!RST) begin
      P_DATA     <= '0;
      cnt        <= '0;
      Parity_ERR <= 1'b0;
      Stop_ERR   <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= complete;
      if (Frame_Start) begin
        P_DATA     <= '0;
        cnt        <= '0;
        Parity_ERR <= 1'b0;
        Stop_ERR   <= 1'b0;
      end else if (strobe)
        case (state)
          DATA: begin
            P_DATA <= P_DATA | (Data_Width'(Sampled_bit) << cnt);
            cnt    <= cnt + Len_Width'(1);
          end
          PARITY:  Parity_ERR <= Sampled_bit != exp_par;
          STOP1:   Stop_ERR   <= ~Sampled_bit;
          STOP2:   Stop_ERR   <= Stop_ERR | ~Sampled_bit;
          default: ;
        endcase
    end

`ifdef UART_RX_ERR_COUNT_EN
  // Saturating per-frame error counters; a clear overrides a same-cycle increment
  always_ff @(posedge CLK or negedge RST)
    if (!RST) begin
      Parity_ERR_CNT <= '0;
      Stop_ERR_CNT   <= '0;
    end else if (Cnt_Clr) begin
      Parity_ERR_CNT <= '0;
      Stop_ERR_CNT   <= '0;
    end else if (done_q) begin
      if (Parity_ERR && !(&Parity_ERR_CNT)) Parity_ERR_CNT <= Parity_ERR_CNT + Cnt_Width'(1);
      if (Stop_ERR && !(&Stop_ERR_CNT)) Stop_ERR_CNT <= Stop_ERR_CNT + Cnt_Width'(1);
    end
`endif

endmodule

// File: tb/tb_uart_rx_frame_check.sv
// tb_uart_rx_frame_check: directed frames with a scoreboard queue checked by a Frame_Done monitor
module tb_uart_rx_frame_check;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       Frame_Start = 1'b0, Bit_Valid = 1'b0, Sampled_bit = 1'b0;
  logic [3:0] Data_Len = '0;
  logic       Parity_EN = 1'b0, Stop_Bits = 1'b0;
  logic [1:0] Parity_MODE = '0;
  logic [7:0] P_DATA;
  logic       Frame_Done, Data_Valid, Parity_ERR, Stop_ERR, Busy;
`ifdef UART_RX_ERR_COUNT_EN
  logic       Cnt_Clr = 1'b0;
  logic [1:0] Parity_ERR_CNT, Stop_ERR_CNT;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic [7:0] d;
    bit         pe;
    bit         se;
    int         c;
  } exp_t;
  exp_t q[$];

  uart_rx_frame_check #(
    .Data_Width (8),
    .Len_Width  (4)
`ifdef UART_RX_ERR_COUNT_EN
    ,
    .Cnt_Width  (2)
`endif
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .Frame_Start (Frame_Start),
    .Bit_Valid   (Bit_Valid),
    .Sampled_bit (Sampled_bit),
    .Data_Len    (Data_Len),
    .Parity_EN   (Parity_EN),
    .Parity_MODE (Parity_MODE),
    .Stop_Bits   (Stop_Bits),
    .P_DATA      (P_DATA),
    .Frame_Done  (Frame_Done),
    .Data_Valid  (Data_Valid),
    .Parity_ERR  (Parity_ERR),
    .Stop_ERR    (Stop_ERR),
    .Busy        (Busy)
`ifdef UART_RX_ERR_COUNT_EN
    ,
    .Cnt_Clr        (Cnt_Clr),
    .Parity_ERR_CNT (Parity_ERR_CNT),
    .Stop_ERR_CNT   (Stop_ERR_CNT)
`endif
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every Frame_Done must match the oldest expected frame, including its cycle
  always @(negedge CLK) begin
    if (RST && Frame_Done) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got Frame_Done=1 expected no frame pending (P_DATA=%0h)", P_DATA);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("p_data", P_DATA, e.d);
        chk("parity_err", Parity_ERR, e.pe);
        chk("stop_err", Stop_ERR, e.se);
        chk("data_valid", Data_Valid, !e.pe && !e.se);
        chk("done_latency", cyc, e.c);
      end
    end
    if (RST && !Frame_Done && Data_Valid) begin
      checks++;
      errors++;
      $display("FAIL valid_without_done: got Data_Valid=1 expected 0");
    end
  end

  task automatic send_bit(input logic b);
    @(negedge CLK);
    Bit_Valid = 1'b1;
    Sampled_bit = b;
    @(posedge CLK);
    #1 Bit_Valid = 1'b0;
    Sampled_bit = 1'($urandom_range(0, 1));
  endtask

  // Pulse Frame_Start, then scramble config inputs to prove they were latched
  task automatic start(input logic [3:0] len, input bit pen, input logic [1:0] mode, input bit st2, input bit bv);
    @(negedge CLK);
    Frame_Start = 1'b1;
    Data_Len = len;
    Parity_EN = pen;
    Parity_MODE = mode;
    Stop_Bits = st2;
    Bit_Valid = bv;
    Sampled_bit = 1'b1;
    @(posedge CLK);
    #1 Frame_Start = 1'b0;
    Bit_Valid = 1'b0;
    Data_Len = 4'($urandom_range(0, 15));
    Parity_EN = ~pen;
    Parity_MODE = ~mode;
    Stop_Bits = ~st2;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (q.size() != 0 && n < 10) begin
      @(negedge CLK);
      n++;
    end
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got %0d frames pending expected 0", q.size());
      q.delete();
    end
    @(negedge CLK);
    chk("busy_after_frame", Busy, 0);
  endtask

  task automatic frame(input logic [3:0] len, input int nbits, input bit pen, input logic [1:0] mode,
                       input bit st2, input logic [7:0] data, input bit pbit, input bit s1, input bit s2,
                       input logic [7:0] exp_d, input bit exp_pe, input bit exp_se, input bit bv);
    exp_t e;
    start(len, pen, mode, st2, bv);
    for (int i = 0; i < nbits; i++) send_bit(data[i]);
    if (pen) send_bit(pbit);
    send_bit(s1);
    if (st2) send_bit(s2);
    e.d = exp_d;
    e.pe = exp_pe;
    e.se = exp_se;
    e.c = cyc;
    q.push_back(e);
    wait_drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected completion");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_p_data", P_DATA, 0);
    chk("rst_busy", Busy, 0);
    chk("rst_done", Frame_Done, 0);
    chk("rst_errs", {Parity_ERR, Stop_ERR, Data_Valid}, 0);
    @(negedge CLK) RST = 1'b1;
    send_bit(1'b1);
    chk("idle_bit_ignored_busy", Busy, 0);
    chk("idle_bit_ignored_data", P_DATA, 0);

    frame(4'd8, 8, 1, 2'b00, 0, 8'hA5, 0, 1, 0, 8'hA5, 0, 0, 0);
    frame(4'd7, 7, 1, 2'b01, 0, 8'h41, 0, 1, 0, 8'h41, 1, 0, 0);
    frame(4'd7, 7, 1, 2'b01, 0, 8'h41, 1, 1, 0, 8'h41, 0, 0, 0);
    frame(4'd5, 5, 0, 2'b00, 1, 8'h15, 0, 1, 0, 8'h15, 0, 1, 0);
    frame(4'd8, 8, 1, 2'b10, 0, 8'h00, 0, 1, 0, 8'h00, 1, 0, 0);
    frame(4'd8, 8, 1, 2'b11, 0, 8'h00, 0, 1, 0, 8'h00, 0, 0, 0);
    frame(4'd6, 6, 1, 2'b00, 0, 8'h2B, 0, 0, 0, 8'h2B, 0, 1, 0);
    frame(4'd8, 8, 1, 2'b00, 0, 8'h07, 1, 1, 0, 8'h07, 0, 0, 0);
    frame(4'd0, 8, 0, 2'b00, 0, 8'hFF, 0, 1, 0, 8'hFF, 0, 0, 0);
    frame(4'd12, 8, 0, 2'b00, 1, 8'h81, 0, 1, 1, 8'h81, 0, 0, 0);
    frame(4'd5, 5, 0, 2'b00, 0, 8'hFF, 0, 1, 0, 8'h1F, 0, 0, 0);

    start(4'd8, 1, 2'b00, 0, 0);
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b1);
    frame(4'd8, 8, 1, 2'b00, 0, 8'h3C, 0, 1, 0, 8'h3C, 0, 0, 1);
    chk("hold_p_data", P_DATA, 8'h3C);

    start(4'd8, 1, 2'b00, 0, 0);
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b1);
    chk("mid_frame_busy", Busy, 1);
    chk("mid_frame_p_data", P_DATA, 8'h07);
    @(negedge CLK) RST = 1'b0;
    #1;
    chk("midrst_p_data", P_DATA, 0);
    chk("midrst_busy", Busy, 0);
    chk("midrst_flags", {Frame_Done, Data_Valid, Parity_ERR, Stop_ERR}, 0);
    @(negedge CLK) RST = 1'b1;
    repeat (3) send_bit(1'b0);
    chk("after_rst_idle", Busy, 0);

`ifdef UART_RX_ERR_COUNT_EN
    @(negedge CLK) Cnt_Clr = 1'b1;
    @(negedge CLK) Cnt_Clr = 1'b0;
    chk("cnt_cleared", Parity_ERR_CNT, 0);
    for (int k = 0; k < 5; k++) frame(4'd8, 8, 1, 2'b10, 0, 8'h00, 0, 1, 0, 8'h00, 1, 0, 0);
    chk("par_cnt_sat", Parity_ERR_CNT, 2'd3);
    chk("stop_cnt", Stop_ERR_CNT, 2'd0);
    @(negedge CLK) Cnt_Clr = 1'b1;
    @(negedge CLK) Cnt_Clr = 1'b0;
    chk("par_cnt_clr", Parity_ERR_CNT, 0);
`endif

    wait_drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
